// File: rtl/itag_array_assoc.sv
// N-way set-associative instruction-cache tag/valid array with registered lookup,
// fill victim selection (match, then first invalid, then round-robin) and a set-walking flush.
module itag_array_assoc #(
  parameter int WAYS  = 2,
  parameter int WAY_W = 1,
  parameter int SETS  = 32,
  parameter int IDX_W = 5,
  parameter int TAG_W = 23
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             lookup_en,
  input  logic [IDX_W-1:0] lookup_index,
  input  logic [TAG_W-1:0] lookup_tag,
  output logic             ready,
  output logic             resp_valid,
  output logic             hit,
  output logic [WAY_W-1:0] hit_way,
  input  logic             fill_en,
  input  logic [IDX_W-1:0] fill_index,
  input  logic [TAG_W-1:0] fill_tag,
  output logic [WAY_W-1:0] fill_way,
  input  logic             flush,
  output logic             flush_done
);

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_FLUSH = 2'd1,
    ST_DONE  = 2'd2
  } state_t;

  localparam logic [IDX_W:0]   CNT_LAST = (IDX_W+1)'(SETS-1);
  localparam logic [IDX_W:0]   CNT_ONE  = (IDX_W+1)'(1'b1);
  localparam logic [WAY_W-1:0] PTR_ONE  = WAY_W'(1'b1);

  state_t           state_r, state_nxt_s;
  logic [IDX_W:0]   cnt_r, cnt_nxt_s;
  logic [WAYS-1:0]  valid_r [SETS];
  logic [TAG_W-1:0] tag_r   [SETS][WAYS];
  logic [WAY_W-1:0] ptr_r   [SETS];

  logic             resp_valid_r, hit_r;
  logic [WAY_W-1:0] hit_way_r;

  logic             ready_s, lookup_fire_s, fill_fire_s;
  logic             look_hit_s;
  logic [WAY_W-1:0] look_way_s;
  logic             match_found_s, inv_found_s, victim_s;
  logic [WAY_W-1:0] match_way_s, inv_way_s, fill_way_s, ptr_adv_s;
  logic [IDX_W-1:0] clr_idx_s;

  assign ready_s       = (state_r == ST_IDLE);
  assign lookup_fire_s = lookup_en && ready_s;
  assign fill_fire_s   = fill_en && ready_s;
  assign clr_idx_s     = cnt_r[IDX_W-1:0];

  // Lookup compare; descending scan so the lowest matching way wins.
  always_comb begin
    look_hit_s = 1'b0;
    look_way_s = {WAY_W{1'b0}};
    for (int w = WAYS - 1; w >= 0; w--) begin
      if (valid_r[lookup_index][w] && (tag_r[lookup_index][w] == lookup_tag)) begin
        look_hit_s = 1'b1;
        look_way_s = WAY_W'(w);
      end else begin
        look_hit_s = look_hit_s;
        look_way_s = look_way_s;
      end
    end
  end

  // Fill way selection: existing copy, else lowest invalid way, else round-robin victim.
  always_comb begin
    match_found_s = 1'b0;
    match_way_s   = {WAY_W{1'b0}};
    inv_found_s   = 1'b0;
    inv_way_s     = {WAY_W{1'b0}};
    for (int w = WAYS - 1; w >= 0; w--) begin
      if (valid_r[fill_index][w] && (tag_r[fill_index][w] == fill_tag)) begin
        match_found_s = 1'b1;
        match_way_s   = WAY_W'(w);
      end else if (!valid_r[fill_index][w]) begin
        inv_found_s = 1'b1;
        inv_way_s   = WAY_W'(w);
      end else begin
        match_found_s = match_found_s;
        inv_found_s   = inv_found_s;
      end
    end
    victim_s = !match_found_s && !inv_found_s;
    if (match_found_s) begin
      fill_way_s = match_way_s;
    end else if (inv_found_s) begin
      fill_way_s = inv_way_s;
    end else begin
      fill_way_s = ptr_r[fill_index];
    end
    if (WAYS == 1) begin
      ptr_adv_s = {WAY_W{1'b0}};
    end else begin
      ptr_adv_s = ptr_r[fill_index] + PTR_ONE;
    end
  end

  // Flush sequencer next-state.
  always_comb begin
    state_nxt_s = state_r;
    cnt_nxt_s   = cnt_r;
    case (state_r)
      ST_IDLE: begin
        if (flush) begin
          state_nxt_s = ST_FLUSH;
          cnt_nxt_s   = {(IDX_W+1){1'b0}};
        end else begin
          state_nxt_s = ST_IDLE;
        end
      end
      ST_FLUSH: begin
        if (cnt_r == CNT_LAST) begin
          state_nxt_s = ST_DONE;
        end else begin
          cnt_nxt_s = cnt_r + CNT_ONE;
        end
      end
      ST_DONE:  state_nxt_s = ST_IDLE;
      default:  state_nxt_s = ST_IDLE;
    endcase
  end

  // Flush sequencer state register.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_r <= ST_IDLE;
      cnt_r   <= {(IDX_W+1){1'b0}};
    end else begin
      state_r <= state_nxt_s;
      cnt_r   <= cnt_nxt_s;
    end
  end

  // Valid bits and replacement pointers: fills while idle, one set cleared per flush cycle.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      for (int s = 0; s < SETS; s++) begin
        valid_r[s] <= {WAYS{1'b0}};
        ptr_r[s]   <= {WAY_W{1'b0}};
      end
    end else if (fill_fire_s) begin
      valid_r[fill_index][fill_way_s] <= 1'b1;
      if (victim_s) begin
        ptr_r[fill_index] <= ptr_adv_s;
      end
    end else if (state_r == ST_FLUSH) begin
      valid_r[clr_idx_s] <= {WAYS{1'b0}};
      ptr_r[clr_idx_s]   <= {WAY_W{1'b0}};
    end
  end

  // Tag storage carries no reset; valid bits qualify it.
  always_ff @(posedge clk) begin
    if (reset && fill_fire_s) begin
      tag_r[fill_index][fill_way_s] <= fill_tag;
    end
  end

  // Lookup response register; hit fields are zero whenever no response is presented.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      resp_valid_r <= 1'b0;
      hit_r        <= 1'b0;
      hit_way_r    <= {WAY_W{1'b0}};
    end else if (lookup_fire_s) begin
      resp_valid_r <= 1'b1;
      hit_r        <= look_hit_s;
      hit_way_r    <= look_way_s;
    end else begin
      resp_valid_r <= 1'b0;
      hit_r        <= 1'b0;
      hit_way_r    <= {WAY_W{1'b0}};
    end
  end

  assign ready      = ready_s;
  assign resp_valid = resp_valid_r;
  assign hit        = hit_r;
  assign hit_way    = hit_way_r;
  assign fill_way   = fill_way_s;
  assign flush_done = (state_r == ST_DONE);

endmodule

// File: doc/itag_array_assoc.md
Name: itag_array_assoc

Overview:
- Parametrised N-way set-associative tag/valid array for the instruction cache; generalises the single-way direct-mapped tag and valid RAM pair.
- Provides a registered tag lookup with a hit/miss and hit-way result, victim selection on fill, and a multi-cycle flush state machine that invalidates every set.
- Sits between the icache controller and the icache data RAM. The controller uses `hit_way` and `fill_way` to address the data RAM.

Parameters:
- WAYS, 2: associativity; legal values 1, 2, 4.
- WAY_W, 1: log2(WAYS); 0 is illegal, so use 1 when WAYS=1.
- SETS, 32: number of sets; must be a power of 2.
- IDX_W, 5: log2(SETS).
- TAG_W, 23: stored tag width.

Ports:
- clk  in  1  system clock; all state changes on the rising edge.
- reset  in  1  asynchronous, active-low reset.
- lookup_en  in  1  lookup request; sampled only when `ready`=1.
- lookup_index  in  IDX_W  set index for lookup.
- lookup_tag  in  TAG_W  tag to compare.
- ready  out  1  1 when the flush state machine is IDLE.
- resp_valid  out  1  1-cycle pulse carrying the lookup result.
- hit  out  1  result is a hit; qualified by `resp_valid`.
- hit_way  out  WAY_W  way that hit; 0 on miss.
- fill_en  in  1  install `fill_tag` into set `fill_index`; ignored when `ready`=0.
- fill_index  in  IDX_W  set index for fill.
- fill_tag  in  TAG_W  tag to install.
- fill_way  out  WAY_W  way chosen for the fill, combinational from current state; valid whenever `fill_en`=1.
- flush  in  1  start invalidation of all sets; ignored unless `ready`=1.
- flush_done  out  1  1-cycle pulse after the last set is cleared.

Behaviour:
- Reset (reset=0, asynchronous):
  - all valid bits = 0; all per-set round-robin pointers = 0; state = IDLE.
  - `resp_valid`, `hit`, `hit_way`, `flush_done` = 0; `ready` = 1 once reset deasserts.
  - Tag storage is not reset.
- Reset asserted mid-flush or mid-lookup aborts immediately. No `flush_done` or `resp_valid` is produced for the aborted operation.
- Lookup (latency 1):
  - Sampled on edge N when `lookup_en`=1 and `ready`=1; compares against array contents as they stood before edge N.
  - Result registered at edge N and held for the cycle after it: `resp_valid`=1, `hit`=OR over ways of (valid && tag==`lookup_tag`), `hit_way` = lowest matching way.
  - `resp_valid`=0 in every other cycle; `hit` and `hit_way` are forced to 0 when `resp_valid`=0.
- Fill (applied at the edge):
  - Way selection priority:
    1. a valid way whose tag equals `fill_tag` (re-write; no duplicates created);
    2. otherwise the lowest-numbered invalid way;
    3. otherwise the set's round-robin pointer.
  - Selected way gets tag=`fill_tag`, valid=1.
  - The pointer advances by 1 mod WAYS only when case 3 is used.
- Simultaneous lookup and fill to the same set on the same edge: the lookup sees the pre-fill contents (read-before-write).
- Hits never change replacement state.
- Flush state machine:
  - IDLE: `flush`=1 and no reset → FLUSH with counter=0. `ready` goes 0 the cycle after the flush edge. Any lookup or fill on the flush edge itself is still performed.
  - FLUSH: each cycle clear the valid bits of all ways in set[counter] and reset its pointer to 0. counter==SETS-1 → DONE; otherwise counter+1.
  - DONE: `flush_done`=1 for one cycle, `ready`=0 → IDLE.
  - Total: SETS+1 cycles with `ready`=0.
- During FLUSH/DONE, `lookup_en` and `fill_en` are ignored (dropped; no response); `flush` is ignored.
- WAYS=1: `hit_way` and `fill_way` are always 0 and the pointer is unused; behaviour equals a direct-mapped tag plus valid RAM.
- Index and tag arithmetic has no wrap-around beyond the port widths; the flush counter is IDX_W+1 bits wide, so SETS-1 is detectable without overflow.

Test Plan:
- Reset, then lookup idx=5'h0C tag=23'habc → `resp_valid`=1 next cycle, `hit`=0, `hit_way`=0.
- Fill idx=0C tag=abc, then lookup idx=0C tag=abc → `hit`=1, `hit_way`=0. Lookup idx=14 tag=abc → `hit`=0.
- WAYS=2, all fills to idx=3:
  - fill tags 1, 2 → `fill_way` 0, 1;
  - fill tag 3 → way 0 (pointer 0→1);
  - fill tag 4 → way 1;
  - fill tag 4 again → way 1 with the pointer unchanged;
  - then lookup tag 1 → `hit`=0, and lookup tag 3 → `hit`=1, `hit_way`=0.
- Fill idx=7 tag=9 on the same edge as lookup idx=7 tag=9 → first response `hit`=0; a repeat lookup → `hit`=1.
- Populate sets 0 and 31, pulse `flush` → `ready`=0 for exactly 33 cycles, `flush_done` pulses once, `lookup_en` during the flush gives no `resp_valid`; afterwards lookups of both sets → `hit`=0.
- Assert reset at flush counter=10 → `ready`=1, `flush_done` never pulses, and all sets read `hit`=0.
